// File: rtl/verlet_step_scheduler.sv
// verlet_step_scheduler
//   Sequences one core of NODES Verlet nodes through repeated time steps:
//   HALO exchange -> VERLET integrate pulse -> SETTLE wait -> ITERS rounds of
//   even/odd constraint relaxation -> STEP_END. Counts completed steps and
//   pulses done at the end of a run.
//
//   Optional feature macro: HALO_TIMEOUT_EN
//     defined   : HALO gives up after HALO_TIMEOUT cycles without halo_ack,
//                 sets sticky error and ends the run through DONE.
//     undefined : HALO waits indefinitely, error is tied low.
//
// Ports
//   clk, reset       clock, synchronous active-low reset
//   start            begin a run (IDLE only); latches num_steps
//   stop             graceful stop at the next step boundary
//   num_steps        steps to run, 0 = free-run until stop
//   halo_ack         neighbours have published boundary data
//   halo_req         boundary exchange request (HALO)
//   verlet_en        per-node integrate enable (VERLET)
//   constraint_en    per-node constraint enable (even bits / odd bits)
//   phase            current state code
//   busy             high outside IDLE
//   done             one-cycle pulse in DONE
//   step_count       completed steps in the current/last run
//   error            sticky halo timeout flag
module verlet_step_scheduler #(
    parameter int NODES        = 5,
    parameter int ITERS        = 4,
    parameter int SETTLE       = 2,
    parameter int STEP_W       = 32,
    parameter int HALO_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              halo_ack,
    output logic              halo_req,
    output logic [NODES-1:0]  verlet_en,
    output logic [NODES-1:0]  constraint_en,
    output logic [2:0]        phase,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_count,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HALO     = 3'd1,
        S_VERLET   = 3'd2,
        S_SETTLE   = 3'd3,
        S_C_EVEN   = 3'd4,
        S_C_ODD    = 3'd5,
        S_STEP_END = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    localparam int IT_W = $clog2(ITERS + 1);
    localparam int ST_W = $clog2(SETTLE + 1);
    localparam logic [IT_W-1:0] ITER_LAST   = IT_W'(ITERS - 1);
    localparam logic [ST_W-1:0] SETTLE_LOAD = ST_W'(SETTLE - 1);

    // Even/odd node masks: no two adjacent nodes share a phase, so the
    // relaxation never writes both ends of a constraint in one cycle.
    function automatic logic [NODES-1:0] parity_mask(input logic odd);
        logic [NODES-1:0] m;
        m = '0;
        for (int i = 0; i < NODES; i++) m[i] = ((i % 2) == 1) == odd;
        return m;
    endfunction

    localparam logic [NODES-1:0] EVEN_MASK = parity_mask(1'b0);
    localparam logic [NODES-1:0] ODD_MASK  = parity_mask(1'b1);

    state_t            state, next_state;
    logic [STEP_W-1:0] num_steps_q;
    logic [STEP_W-1:0] step_nxt;
    logic              stop_pending;
    logic [IT_W-1:0]   iter_cnt;
    logic [ST_W-1:0]   settle_cnt;
    logic              last_iter;
    logic              run_end;
    logic              halo_expire;

    assign step_nxt  = step_count + STEP_W'(1);
    assign last_iter = (iter_cnt == ITER_LAST);
    // Target of 0 means free-run, so a wrap to 0 never ends the run.
    assign run_end   = stop_pending || ((num_steps_q != '0) && (step_nxt == num_steps_q));

`ifdef HALO_TIMEOUT_EN
    localparam int HT_W = $clog2(HALO_TIMEOUT + 1);
    localparam logic [HT_W-1:0] HALO_LAST = HT_W'(HALO_TIMEOUT - 1);

    logic [HT_W-1:0] halo_cnt;

    // Counts cycles spent in the current HALO visit; the last allowed
    // cycle still accepts halo_ack.
    assign halo_expire = (state == S_HALO) && !halo_ack && (halo_cnt == HALO_LAST);

    always_ff @(posedge clk) begin
        if (!reset)                halo_cnt <= '0;
        else if (state != S_HALO)  halo_cnt <= '0;
        else                       halo_cnt <= halo_cnt + HT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset)                          error <= 1'b0;
        else if (state == S_IDLE && start)   error <= 1'b0;
        else if (halo_expire)                error <= 1'b1;
    end
`else
    assign halo_expire = 1'b0;
    assign error       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:     if (start) next_state = S_HALO;
            S_HALO: begin
                if (halo_ack)         next_state = S_VERLET;
                else if (halo_expire) next_state = S_DONE;
            end
            S_VERLET:   next_state = S_SETTLE;
            S_SETTLE:   if (settle_cnt == '0) next_state = S_C_EVEN;
            S_C_EVEN:   next_state = S_C_ODD;
            S_C_ODD:    next_state = last_iter ? S_STEP_END : S_C_EVEN;
            S_STEP_END: next_state = run_end ? S_DONE : S_HALO;
            S_DONE:     next_state = S_IDLE;
        endcase
    end

    // Run bookkeeping: step target, step counter, stop request, loop counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            num_steps_q  <= '0;
            step_count   <= '0;
            stop_pending <= 1'b0;
            iter_cnt     <= '0;
            settle_cnt   <= '0;
        end else begin
            if (state != S_IDLE && stop) stop_pending <= 1'b1;
            unique case (state)
                S_IDLE: if (start) begin
                    num_steps_q  <= num_steps;
                    step_count   <= '0;
                    stop_pending <= 1'b0;
                    iter_cnt     <= '0;
                end
                S_VERLET:   settle_cnt <= SETTLE_LOAD;
                S_SETTLE:   if (settle_cnt != '0) settle_cnt <= settle_cnt - ST_W'(1);
                S_C_ODD:    iter_cnt <= iter_cnt + IT_W'(1);
                S_STEP_END: begin
                    step_count <= step_nxt;
                    iter_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

    // Output decode of the upcoming state, registered so outputs line up
    // with the state register cycle for cycle.
    logic             halo_req_d, busy_d, done_d;
    logic [NODES-1:0] verlet_en_d, constraint_en_d;

    always_comb begin
        halo_req_d      = (next_state == S_HALO);
        busy_d          = (next_state != S_IDLE);
        done_d          = (next_state == S_DONE);
        verlet_en_d     = (next_state == S_VERLET) ? '1 : '0;
        constraint_en_d = '0;
        if (next_state == S_C_EVEN) constraint_en_d = EVEN_MASK;
        if (next_state == S_C_ODD)  constraint_en_d = ODD_MASK;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase         <= 3'd0;
            halo_req      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            verlet_en     <= '0;
            constraint_en <= '0;
        end else begin
            phase         <= next_state;
            halo_req      <= halo_req_d;
            busy          <= busy_d;
            done          <= done_d;
            verlet_en     <= verlet_en_d;
            constraint_en <= constraint_en_d;
        end
    end

endmodule
